// File: rtl/ntt_masked_addsub_sched.sv
// Issue scheduler, in-flight tracker and result FIFO for the shared masked add/sub datapath.
// Define NTT_ADDSUB_SCHED_PERF_EN to add saturating issue/stall/full performance counters.
module ntt_masked_addsub_sched #(
  parameter int WIDTH      = 46,
  parameter int LATENCY    = 53,
  parameter int TAG_W      = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            zeroize,
  input  logic [1:0]                      req_valid,
  output logic [1:0]                      req_ready,
  input  logic [1:0]                      req_sub,
  input  logic [1:0][TAG_W-1:0]           req_tag,
  input  logic [1:0][1:0][WIDTH-1:0]      req_u,
  input  logic [1:0][1:0][WIDTH-1:0]      req_v,
  output logic [1:0][WIDTH-1:0]           dp_u,
  output logic [1:0][WIDTH-1:0]           dp_v,
  output logic                            dp_sub,
  output logic                            rnd_en,
  input  logic [1:0][WIDTH-1:0]           dp_res,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [1:0][WIDTH-1:0]           out_res,
  output logic [TAG_W-1:0]                out_tag,
  output logic                            out_src,
  output logic                            idle
`ifdef NTT_ADDSUB_SCHED_PERF_EN
  ,
  output logic [31:0]                     perf_issue_cnt,
  output logic [31:0]                     perf_stall_cnt,
  output logic [31:0]                     perf_full_cnt
`endif
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);

  typedef struct packed {
    logic             vld;
    logic [TAG_W-1:0] tag;
    logic             src;
  } dl_t;

  typedef struct packed {
    logic [1:0][WIDTH-1:0] res;
    logic [TAG_W-1:0]      tag;
    logic                  src;
  } fe_t;

  dl_t           dl [LATENCY];
  fe_t           mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] fifo_cnt;
  logic [CW-1:0] inflight;
  logic [CW:0]   used;
  logic          rr;
  logic          gnt;
  logic          credit_ok;
  logic          issue;
  logic          cap;
  logic          pop;

  // Credit counts ops already promised a FIFO slot, so capture never overflows.
  assign used      = {1'b0, inflight} + {1'b0, fifo_cnt};
  assign credit_ok = used < DEPTH_C;
  assign gnt       = req_valid[rr] ? rr : ~rr;
  assign issue     = reset_n & ~zeroize & credit_ok & (|req_valid);
  assign cap       = dl[LATENCY-1].vld;
  assign pop       = out_valid & out_ready;
  assign rnd_en    = issue;

  // Operands are forced to zero when idle so no share lingers on the bus.
  always_comb begin
    req_ready = '0;
    dp_u      = '0;
    dp_v      = '0;
    dp_sub    = 1'b0;
    if (issue) begin
      req_ready[gnt] = 1'b1;
      dp_u           = req_u[gnt];
      dp_v           = req_v[gnt];
      dp_sub         = req_sub[gnt];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < LATENCY; i++) dl[i] <= '0;
    end else if (zeroize) begin
      for (int i = 0; i < LATENCY; i++) dl[i] <= '0;
    end else begin
      dl[0].vld <= issue;
      dl[0].tag <= issue ? req_tag[gnt] : '0;
      dl[0].src <= issue ? gnt : 1'b0;
      for (int i = 1; i < LATENCY; i++) dl[i] <= dl[i-1];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr       <= 1'b0;
      inflight <= '0;
    end else if (zeroize) begin
      rr       <= 1'b0;
      inflight <= '0;
    end else begin
      if (issue) rr <= ~gnt;
      case ({issue, cap})
        2'b10:   inflight <= inflight + CW'(1);
        2'b01:   inflight <= inflight - CW'(1);
        default: inflight <= inflight;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else if (zeroize) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (cap) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({cap, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (cap && !zeroize) begin
      mem[wr_ptr].res <= dp_res;
      mem[wr_ptr].tag <= dl[LATENCY-1].tag;
      mem[wr_ptr].src <= dl[LATENCY-1].src;
    end
  end

  assign out_valid = fifo_cnt != '0;
  assign out_res   = out_valid ? mem[rd_ptr].res : '0;
  assign out_tag   = out_valid ? mem[rd_ptr].tag : '0;
  assign out_src   = out_valid ? mem[rd_ptr].src : 1'b0;
  assign idle      = (inflight == '0) && (fifo_cnt == '0);

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (reset_n && !zeroize && cap)
      assert (fifo_cnt != CW'(FIFO_DEPTH));
  end
`endif

`ifdef NTT_ADDSUB_SCHED_PERF_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_issue_cnt <= '0;
      perf_stall_cnt <= '0;
      perf_full_cnt  <= '0;
    end else if (zeroize) begin
      perf_issue_cnt <= '0;
      perf_stall_cnt <= '0;
      perf_full_cnt  <= '0;
    end else begin
      if (issue && perf_issue_cnt != '1)
        perf_issue_cnt <= perf_issue_cnt + 32'd1;
      if ((|req_valid) && !issue && perf_stall_cnt != '1)
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (!credit_ok && perf_full_cnt != '1)
        perf_full_cnt <= perf_full_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: doc/ntt_masked_addsub_sched.md
Name: ntt_masked_addsub_sched

Overview:
Scheduler and controller for the shared masked add/sub butterfly datapath. The datapath is a fixed-latency (53 clk), non-stallable pipeline.
- Arbitrates two requesters (port 0: NTT/INTT, port 1: PWA/PWS) round-robin.
- Muxes their masked operands into the datapath and tracks in-flight operations with a valid/tag delay line.
- Captures results into a result FIFO. Credit-based issue control guarantees the FIFO never overflows.
- Sits between the NTT control FSMs and the masked add/sub instance in ntt_top.

Parameters:
WIDTH, 46, bit width of each arithmetic share
LATENCY, 53, datapath issue-to-result latency in clks (must be >= 2)
TAG_W, 4, requester tag width carried alongside each operation
FIFO_DEPTH, 8, result FIFO entries (power of two, >= 2)

Ports:
clk  input  1  clock
reset_n  input  1  asynchronous active-low reset
zeroize  input  1  synchronous clear of all state, priority over normal operation
req_valid  input  2  per-requester request valid
req_ready  output  2  per-requester accept; at most one bit set per cycle
req_sub  input  2  per-requester op select: 1 = u-v, 0 = u+v
req_tag  input  2xTAG_W  per-requester tag
req_u  input  2x2xWIDTH  per-requester masked operand u (two shares)
req_v  input  2x2xWIDTH  per-requester masked operand v (two shares)
dp_u  output  2xWIDTH  operand u to datapath
dp_v  output  2xWIDTH  operand v to datapath
dp_sub  output  1  sub select to datapath
rnd_en  output  1  advance external randomness source; equals issue
dp_res  input  2xWIDTH  datapath result shares
out_valid  output  1  FIFO head valid
out_ready  input  1  consumer accept
out_res  output  2xWIDTH  result shares at FIFO head
out_tag  output  TAG_W  tag at FIFO head
out_src  output  1  originating requester of FIFO head
idle  output  1  no in-flight ops and FIFO empty

Behaviour:
Reset and zeroize:
- Reset (async) and zeroize (sync) clear the delay line, FIFO pointers and count, in-flight counter and RR pointer.
- Outputs after reset: req_ready=0, out_valid=0, out_res/out_tag/out_src=0, dp_*=0, rnd_en=0, idle=1.
- Zeroize mid-operation drops all in-flight ops; the FIFO is emptied the next cycle.

Credit and issue:
- credit_ok = (inflight + fifo_count) < FIFO_DEPTH.
- Issue happens when credit_ok and any req_valid is high.
- Grant goes to the requester indicated by the RR pointer if that requester is valid, else to the other.
- The RR pointer flips to the non-granted requester after each grant. A single requester gets back-to-back grants.
- req_ready[g]=1 only for the granted requester, combinationally, in the issue cycle.
- dp_u/dp_v/dp_sub mux the granted requester's inputs. They are zero when not issuing; shares must never be held stale.
- rnd_en=issue.

Delay line and result capture:
- Delay line: LATENCY stages of {valid, tag, src}, shifting every cycle. The entry enters stage 0 on issue.
- The result is captured when the stage LATENCY-1 valid is set: dp_res, tag and src are written into the FIFO that cycle.
- inflight counts set valid bits: +1 on issue, -1 on capture. Simultaneous issue and capture leave it unchanged.

FIFO:
- Standard read/write pointers; out_* reflect the head combinationally from storage.
- Pop on out_valid && out_ready.
- Simultaneous push and pop: count unchanged, and the full condition is unreachable by credit.
- Pop in the same cycle frees one credit the following cycle. Credit is computed from registered counts.
- Assertion: push while full is illegal (verification only).

Throughput and ordering:
- Steady-state rate is 1 op/clk when the consumer never stalls and FIFO_DEPTH >= LATENCY+1. With the default depth of 8, throughput is bounded to FIFO_DEPTH ops per LATENCY+1 window.
- Results leave in issue order.

idle = (inflight==0) && (fifo_count==0).

Optional Feature:
Macro: NTT_ADDSUB_SCHED_PERF_EN.
- Defined: adds 32-bit saturating counters.
  - perf_issue_cnt: issues.
  - perf_stall_cnt: cycles with any req_valid but no issue.
  - perf_full_cnt: cycles with credit_ok=0.
- Counters are exposed as extra output ports and cleared by reset or zeroize.
- Undefined: ports and logic absent; the rest of the behaviour is identical.

Test Plan:
- Single op, req0 valid, sub=0, u=(5,7), v=(3,1), tag=3. Required: req_ready[0] at cycle 0; dp_u=(5,7), dp_v=(3,1); out_valid at cycle LATENCY+1 with tag=3, src=0; idle=1 after pop.
- Both requesters continuously valid, out_ready=1. Required: grants alternate 0,1,0,1; tags return in issue order; no more than 8 issues per 54-cycle window.
- out_ready=0, req0 always valid. Required: exactly 8 issues, then req_ready=0 forever. After one pop, exactly one further issue occurs one cycle later.
- Zeroize asserted at cycle 20 with 5 ops in flight. Required: next cycle idle=1, out_valid=0, and no captures occur afterwards.
- reset_n deasserted asynchronously mid-stream. Required: all outputs are 0 immediately (idle=1); after release, a fresh op completes with correct tag.
- With NTT_ADDSUB_SCHED_PERF_EN defined, run the full-FIFO scenario for 100 cycles. Required: perf_issue_cnt=8; perf_stall_cnt and perf_full_cnt each equal 100 minus the cycles before the credit limit was reached.
